// File: rtl/osd_text_master.sv
// osd_text_master: Avalon-MM initiator for the OSD register slave.
// Packs a character stream into byte-enabled writes to the pointer words
// (addresses 1..8), forwards config writes to address 0 and performs a
// read-modify-write status refresh that sets config bit 1.
//
// Handshake: a request on ch_* / cfg_* transfers on a rising edge where its
// valid and ready are both high; valid may be raised at any time, and the
// request (payload included) must be held until it transfers. ready never
// depends on valid of the same channel.
module osd_text_master #(
    parameter int FLUSH_TIMEOUT = 64,
    parameter int TO_W          = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ch_valid,
    output logic        ch_ready,
    input  logic [4:0]  ch_idx,
    input  logic [7:0]  ch_code,
    input  logic        ch_last,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [31:0] cfg_data,
    input  logic [3:0]  cfg_be,
    input  logic        refresh_req,
    output logic        busy,
    output logic [3:0]  avalon_m_address,
    output logic [31:0] avalon_m_writedata,
    output logic [3:0]  avalon_m_byteenable,
    output logic        avalon_m_write,
    output logic        avalon_m_read,
    output logic        avalon_m_chipselect,
    input  logic [31:0] avalon_m_readdata,
    input  logic        avalon_m_waitrequest_n,
    output logic [2:0]  dbg_state_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_CHAR = 3'd1;
    localparam logic [2:0] S_WR_CFG  = 3'd2;
    localparam logic [2:0] S_RD_CFG  = 3'd3;
    localparam logic [2:0] S_WR_REF  = 3'd4;

    localparam bit              TO_EN    = (FLUSH_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(FLUSH_TIMEOUT);

    logic [2:0]      state_q, state_d;
    logic [2:0]      acc_word_q, acc_word_d;
    logic [31:0]     acc_data_q, acc_data_d;
    logic [3:0]      acc_be_q, acc_be_d;
    logic            pend_q, pend_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [31:0]     cfg_data_q, cfg_data_d;
    logic [3:0]      cfg_be_q, cfg_be_d;
    logic [31:0]     rmw_q, rmw_d;
    // Holds both ready outputs low until the first edge after reset release.
    logic            en_q;

    logic       idle;
    logic [1:0] ch_lane;
    logic [2:0] ch_word;
    logic       ch_merge;
    logic       ch_acc;
    logic       cfg_acc;
    logic       flush;

    assign idle     = (state_q == S_IDLE);
    assign ch_lane  = ch_idx[1:0];
    assign ch_word  = ch_idx[4:2];
    // A char merges if the accumulator is empty or it targets the same
    // word on a lane that is still free.
    assign ch_merge = (acc_be_q == 4'd0) ||
                      ((ch_word == acc_word_q) && !acc_be_q[ch_lane]);

    // Config and pending refresh outrank chars; config waits for an empty
    // accumulator so chars already taken reach the bus first.
    assign ch_ready  = en_q && idle && !cfg_valid && !pend_q && ch_merge;
    assign cfg_ready = en_q && idle && (acc_be_q == 4'd0) && !pend_q;
    assign ch_acc    = ch_valid && ch_ready;
    assign cfg_acc   = cfg_valid && cfg_ready;

    assign busy        = !idle || (acc_be_q != 4'd0) || pend_q;
    assign dbg_state_o = state_q;

    // Next-state logic: accumulation, flush decisions and transfer sequencing.
    always_comb begin
        state_d    = state_q;
        acc_word_d = acc_word_q;
        acc_data_d = acc_data_q;
        acc_be_d   = acc_be_q;
        pend_d     = pend_q;
        to_d       = to_q;
        cfg_data_d = cfg_data_q;
        cfg_be_d   = cfg_be_q;
        rmw_d      = rmw_q;
        flush      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_acc) begin
                    cfg_data_d = cfg_data;
                    cfg_be_d   = cfg_be;
                    state_d    = S_WR_CFG;
                end else if ((acc_be_q == 4'd0) && pend_q) begin
                    pend_d  = 1'b0;
                    state_d = S_RD_CFG;
                end else begin
                    if (ch_acc) begin
                        acc_data_d[{ch_lane, 3'b000} +: 8] = ch_code;
                        acc_be_d[ch_lane] = 1'b1;
                        acc_word_d        = ch_word;
                        to_d              = '0;
                    end else if (TO_EN && (acc_be_q != 4'd0)) begin
                        to_d = to_q + 1'b1;
                    end
                    // Flush on the accept edge itself when the new char
                    // completes the word or is marked last.
                    flush = (acc_be_d != 4'd0) &&
                            ((ch_acc && ch_last) ||
                             (acc_be_d == 4'hF) ||
                             (ch_valid && !ch_merge) ||
                             cfg_valid || pend_q ||
                             (TO_EN && !ch_acc && (to_d == TO_LIMIT)));
                    if (flush) begin
                        state_d = S_WR_CHAR;
                        to_d    = '0;
                    end
                end
            end
            S_WR_CHAR: begin
                if (avalon_m_waitrequest_n) begin
                    acc_be_d   = 4'd0;
                    acc_data_d = 32'd0;
                    state_d    = S_IDLE;
                end
            end
            S_WR_CFG: begin
                if (avalon_m_waitrequest_n) state_d = S_IDLE;
            end
            S_RD_CFG: begin
                if (avalon_m_waitrequest_n) begin
                    rmw_d   = avalon_m_readdata;
                    state_d = S_WR_REF;
                end
            end
            S_WR_REF: begin
                if (avalon_m_waitrequest_n) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A request seen during a refresh queues exactly one more.
        if (refresh_req) pend_d = 1'b1;
    end

    // Bus outputs decode only registered state, so they move on clock edges.
    always_comb begin
        avalon_m_chipselect = 1'b0;
        avalon_m_write      = 1'b0;
        avalon_m_read       = 1'b0;
        avalon_m_address    = 4'd0;
        avalon_m_writedata  = 32'd0;
        avalon_m_byteenable = 4'd0;
        case (state_q)
            S_WR_CHAR: begin
                avalon_m_chipselect = 1'b1;
                avalon_m_write      = 1'b1;
                avalon_m_address    = {1'b0, acc_word_q} + 4'd1;
                avalon_m_writedata  = acc_data_q;
                avalon_m_byteenable = acc_be_q;
            end
            S_WR_CFG: begin
                avalon_m_chipselect = 1'b1;
                avalon_m_write      = 1'b1;
                avalon_m_writedata  = cfg_data_q;
                avalon_m_byteenable = cfg_be_q;
            end
            S_RD_CFG: begin
                avalon_m_chipselect = 1'b1;
                avalon_m_read       = 1'b1;
                avalon_m_byteenable = 4'hF;
            end
            S_WR_REF: begin
                avalon_m_chipselect = 1'b1;
                avalon_m_write      = 1'b1;
                avalon_m_writedata  = rmw_q | 32'h0000_0002;
                avalon_m_byteenable = 4'hF;
            end
            default: ;
        endcase
    end

    // State registers; reset aborts any transfer in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            acc_word_q <= 3'd0;
            acc_data_q <= 32'd0;
            acc_be_q   <= 4'd0;
            pend_q     <= 1'b0;
            to_q       <= '0;
            cfg_data_q <= 32'd0;
            cfg_be_q   <= 4'd0;
            rmw_q      <= 32'd0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_word_q <= acc_word_d;
            acc_data_q <= acc_data_d;
            acc_be_q   <= acc_be_d;
            pend_q     <= pend_d;
            to_q       <= to_d;
            cfg_data_q <= cfg_data_d;
            cfg_be_q   <= cfg_be_d;
            rmw_q      <= rmw_d;
            en_q       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_osd_text_master.sv
// Bench for osd_text_master: directed scenarios plus randomized packing and
// config/refresh traffic checked against a transaction-level model.
module tb_osd_text_master;

    localparam int TO = 64;
    typedef logic [40:0] rec_t; // {read, address, data, byteenable}

    // ---- clock / reset ----
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---- main DUT signals ----
    logic        ch_valid = 0, ch_last = 0, cfg_valid = 0, refresh_req = 0;
    logic [4:0]  ch_idx = 0;
    logic [7:0]  ch_code = 0;
    logic [31:0] cfg_data = 0, rd_val = 0;
    logic [3:0]  cfg_be = 0;
    logic        ch_ready, cfg_ready, busy, wr, rd, cs, wn;
    logic [3:0]  addr, be;
    logic [31:0] wdata;
    logic [2:0]  dbg;
    logic        rnd_bit = 1'b1, wn_force = 1'b1;
    bit          rand_wn = 0;
    assign wn = rand_wn ? rnd_bit : wn_force;
    always @(posedge clk) begin #1; rnd_bit = 1'($urandom_range(0, 1)); end

    // ---- second DUT with timeout flushing disabled ----
    logic        z_ch_valid = 0, z_ch_last = 0, z_zero = 0, z_one = 1;
    logic [4:0]  z_ch_idx = 0;
    logic [7:0]  z_ch_code = 0;
    logic [31:0] z_zero32 = 0;
    logic [3:0]  z_zero4 = 0;
    logic        z_ch_ready, z_cfg_ready, z_busy, z_wr, z_rd, z_cs;
    logic [3:0]  z_addr, z_be;
    logic [31:0] z_wdata;
    logic [2:0]  z_dbg;

    osd_text_master #(.FLUSH_TIMEOUT(TO), .TO_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_idx(ch_idx),
        .ch_code(ch_code), .ch_last(ch_last),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .cfg_be(cfg_be), .refresh_req(refresh_req), .busy(busy),
        .avalon_m_address(addr), .avalon_m_writedata(wdata),
        .avalon_m_byteenable(be), .avalon_m_write(wr), .avalon_m_read(rd),
        .avalon_m_chipselect(cs), .avalon_m_readdata(rd_val),
        .avalon_m_waitrequest_n(wn), .dbg_state_o(dbg)
    );

    osd_text_master #(.FLUSH_TIMEOUT(0), .TO_W(8)) dut_z (
        .clk_i(clk), .rst_ni(rst_ni),
        .ch_valid(z_ch_valid), .ch_ready(z_ch_ready), .ch_idx(z_ch_idx),
        .ch_code(z_ch_code), .ch_last(z_ch_last),
        .cfg_valid(z_zero), .cfg_ready(z_cfg_ready), .cfg_data(z_zero32),
        .cfg_be(z_zero4), .refresh_req(z_zero), .busy(z_busy),
        .avalon_m_address(z_addr), .avalon_m_writedata(z_wdata),
        .avalon_m_byteenable(z_be), .avalon_m_write(z_wr), .avalon_m_read(z_rd),
        .avalon_m_chipselect(z_cs), .avalon_m_readdata(z_zero32),
        .avalon_m_waitrequest_n(z_one), .dbg_state_o(z_dbg)
    );

    // ---- scoreboard ----
    int   errors = 0, checks = 0;
    rec_t obs_q[$];
    rec_t exp_q[$];
    int   rw_clash = 0;
    int   z_wr_cnt = 0;
    rec_t z_rec = '0;

    // Bus monitor: logs every completed transfer of both DUTs.
    always @(negedge clk) begin
        if (rst_ni && cs && wn) obs_q.push_back({rd, addr, (rd ? rd_val : wdata), be});
        if (rd && wr) rw_clash++;
        if (rst_ni && z_cs && z_wr) begin
            z_wr_cnt++;
            z_rec = {z_rd, z_addr, z_wdata, z_be};
        end
    end

    // ---- driver tasks ----
    task automatic send_char(input logic [4:0] idx, input logic [7:0] code,
                             input logic last, output logic first_rdy, output bit ok);
        logic rdy;
        ok = 0; first_rdy = 0;
        ch_valid = 1; ch_idx = idx; ch_code = code; ch_last = last;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); rdy = ch_ready;
            if (i == 0) first_rdy = rdy;
            @(posedge clk); #1;
            if (rdy) begin ok = 1; break; end
        end
        ch_valid = 0; ch_last = 0;
    endtask

    task automatic send_cfg(input logic [31:0] d, input logic [3:0] b, output bit ok);
        logic rdy;
        ok = 0;
        cfg_valid = 1; cfg_data = d; cfg_be = b;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); rdy = cfg_ready;
            @(posedge clk); #1;
            if (rdy) begin ok = 1; break; end
        end
        cfg_valid = 0;
    endtask

    task automatic pulse_refresh();
        refresh_req = 1; @(posedge clk); #1; refresh_req = 0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        @(posedge clk); #1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        @(posedge clk); #1;
    endtask

    // ---- tests ----
    task automatic test_reset();
        bit ok;
        rst_ni = 0; ch_valid = 1; ch_idx = 5'd5; ch_code = 8'h33;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ch_ready, cfg_ready, busy, dbg} !== '0)
            $display("FAIL reset_hs: got %b expected 0", {ch_ready, cfg_ready, busy, dbg});
            if ({ch_ready, cfg_ready, busy, dbg} !== '0) errors++;
        checks++;
        if ({cs, wr, rd, addr, wdata, be} !== '0) begin
            errors++;
            $display("FAIL reset_bus: got %h expected 0", {cs, wr, rd, addr, wdata, be});
        end
        checks++;
        if ({z_ch_ready, z_cfg_ready, z_busy, z_cs, z_wr, z_rd, z_addr, z_wdata, z_be} !== '0) begin
            errors++;
            $display("FAIL reset_z: outputs not all zero");
        end
        @(posedge clk); #1; rst_ni = 1; ch_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
        checks++;
        if (ch_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ch_ready: got %b expected 1", ch_ready); end
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL post_reset_cfg_ready: got %b expected 1", cfg_ready); end
        ok = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_packing();
        logic fr; bit ok; rec_t want;
        obs_q.delete();
        for (int i = 0; i < 4; i++) begin
            send_char(5'(4 + i), 8'(8'h41 + i), 1'b0, fr, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL pack_accept: char %0d not accepted", i); end
        end
        @(negedge clk);
        checks++;
        if ({wr, addr, wdata, be} !== {1'b1, 4'd2, 32'h44434241, 4'hF}) begin
            errors++;
            $display("FAIL pack_start: got %h expected %h", {wr, addr, wdata, be},
                     {1'b1, 4'd2, 32'h44434241, 4'hF});
        end
        wait_idle(20, ok);
        want = {1'b0, 4'd2, 32'h44434241, 4'hF};
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== want) begin
            errors++;
            $display("FAIL pack_write: got %0d transfers first %h expected 1 of %h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : rec_t'(0), want);
        end
    endtask

    task automatic test_partial_break();
        logic fr; bit ok;
        obs_q.delete(); exp_q.delete();
        exp_q.push_back({1'b0, 4'd1, 32'h00000010, 4'b0001});
        exp_q.push_back({1'b0, 4'd2, 32'h00002000, 4'b0010});
        send_char(5'd0, 8'h10, 1'b0, fr, ok);
        send_char(5'd5, 8'h20, 1'b1, fr, ok);
        checks++;
        if (fr !== 1'b0) begin errors++; $display("FAIL break_ready: got %b expected 0", fr); end
        checks++;
        if (!ok) begin errors++; $display("FAIL break_accept: idx 5 never accepted"); end
        wait_idle(20, ok);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL break_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL break_write%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_timeout();
        logic fr; bit ok, seen; int a, delta;
        obs_q.delete();
        send_char(5'd31, 8'h7F, 1'b0, fr, ok);
        a = cyc; seen = 0; delta = 0;
        for (int i = 0; i < 3 * TO; i++) begin
            @(negedge clk);
            if (wr) begin seen = 1; delta = cyc - a; break; end
        end
        checks++;
        if (!seen || delta < TO - 1 || delta > TO + 1) begin
            errors++;
            $display("FAIL timeout_delay: got seen=%0d delay=%0d expected %0d+-1", seen, delta, TO);
        end
        wait_idle(20, ok);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== {1'b0, 4'd8, 32'h7F000000, 4'b1000}) begin
            errors++;
            $display("FAIL timeout_write: got %0d transfers first %h expected %h", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0] : rec_t'(0), {1'b0, 4'd8, 32'h7F000000, 4'b1000});
        end
    endtask

    task automatic test_no_timeout();
        logic rdy; int base; bit ok;
        base = z_wr_cnt;
        z_ch_valid = 1; z_ch_idx = 5'd31; z_ch_code = 8'h7F; z_ch_last = 0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); rdy = z_ch_ready; @(posedge clk); #1;
            if (rdy) begin ok = 1; break; end
        end
        z_ch_valid = 0;
        repeat (3 * TO) @(posedge clk);
        #1;
        checks++;
        if (!ok || z_wr_cnt != base) begin
            errors++;
            $display("FAIL notimeout_hold: got accept=%0d writes=%0d expected 1 and 0", ok, z_wr_cnt - base);
        end
        z_ch_valid = 1; z_ch_idx = 5'd30; z_ch_code = 8'h7E; z_ch_last = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); rdy = z_ch_ready; @(posedge clk); #1;
            if (rdy) break;
        end
        z_ch_valid = 0; z_ch_last = 0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (z_wr_cnt != base + 1 || z_rec !== {1'b0, 4'd8, 32'h7F7E0000, 4'b1100}) begin
            errors++;
            $display("FAIL notimeout_last: got writes=%0d rec=%h expected 1 of %h", z_wr_cnt - base,
                     z_rec, {1'b0, 4'd8, 32'h7F7E0000, 4'b1100});
        end
    endtask

    task automatic test_waitrequest();
        bit ok;
        obs_q.delete();
        wn_force = 0;
        cfg_valid = 1; cfg_data = 32'h00006005; cfg_be = 4'h3;
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL wait_cfg_ready: got %b expected 1", cfg_ready); end
        @(posedge clk); #1; cfg_valid = 0;
        for (int i = 0; i < 4; i++) begin
            wn_force = (i == 3);
            @(negedge clk);
            checks++;
            if ({cfg_ready, wr, rd, addr, wdata, be} !== {1'b0, 1'b1, 1'b0, 4'd0, 32'h00006005, 4'h3}) begin
                errors++;
                $display("FAIL wait_hold%0d: got %h expected %h", i, {cfg_ready, wr, rd, addr, wdata, be},
                         {1'b0, 1'b1, 1'b0, 4'd0, 32'h00006005, 4'h3});
            end
            @(posedge clk); #1;
        end
        wn_force = 1;
        @(negedge clk);
        checks++;
        if (cs !== 1'b0 || obs_q.size() != 1) begin
            errors++;
            $display("FAIL wait_complete: got cs=%b transfers=%0d expected 0 and 1", cs, obs_q.size());
        end
        wait_idle(10, ok);
    endtask

    task automatic test_refresh();
        bit ok, seen;
        obs_q.delete(); exp_q.delete();
        rd_val = 32'h00006005;
        repeat (2) begin
            exp_q.push_back({1'b1, 4'd0, 32'h00006005, 4'hF});
            exp_q.push_back({1'b0, 4'd0, 32'h00006007, 4'hF});
        end
        wn_force = 0;
        pulse_refresh();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rd) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL refresh_read_start: got no read expected read"); end
        @(posedge clk); #1;
        refresh_req = 1; wn_force = 1;
        @(posedge clk); #1; refresh_req = 0;
        wait_idle(50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL refresh_idle: got busy=1 expected 0"); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL refresh_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL refresh_xfer%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_ordering();
        logic fr; bit ok;
        obs_q.delete(); exp_q.delete();
        rd_val = 32'h12340000;
        exp_q.push_back({1'b0, 4'd3, 32'h00000055, 4'b0001});
        exp_q.push_back({1'b1, 4'd0, 32'h12340000, 4'hF});
        exp_q.push_back({1'b0, 4'd0, 32'h12340002, 4'hF});
        send_char(5'd8, 8'h55, 1'b0, fr, ok);
        pulse_refresh();
        wait_idle(50, ok);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL order_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL order_xfer%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    // Random char stream; the model groups chars into words the way the
    // slave should see them: a word closes when the next char cannot join
    // it, when all four lanes are filled, or after a char marked last.
    task automatic test_random_pack();
        logic fr; bit ok; int nacc;
        logic [2:0] w, prev_w; logic [1:0] l; logic [7:0] code; logic last;
        logic [3:0] m_be; logic [2:0] m_word; logic [31:0] m_data;
        obs_q.delete(); exp_q.delete();
        m_be = 0; m_word = 0; m_data = 0; prev_w = 0; nacc = 0;
        rand_wn = 1;
        for (int i = 0; i < 40; i++) begin
            w    = ($urandom_range(0, 9) < 6) ? prev_w : 3'($urandom_range(0, 7));
            l    = 2'($urandom_range(0, 3));
            code = 8'($urandom);
            last = (i == 39) || ($urandom_range(0, 9) == 0);
            prev_w = w;
            if (m_be != 0 && (w != m_word || m_be[l])) begin
                exp_q.push_back({1'b0, 4'(m_word + 1), m_data, m_be});
                m_be = 0; m_data = 0;
            end
            m_word = w; m_be[l] = 1'b1; m_data[l * 8 +: 8] = code;
            if (m_be == 4'hF || last) begin
                exp_q.push_back({1'b0, 4'(m_word + 1), m_data, m_be});
                m_be = 0; m_data = 0;
            end
            send_char({w, l}, code, last, fr, ok);
            if (ok) nacc++;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        wait_idle(300, ok);
        rand_wn = 0;
        checks++;
        if (nacc != 40 || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rpack_count: got accepted=%0d writes=%0d expected 40 and %0d",
                     nacc, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rpack_write%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random_cfg_refresh();
        bit ok; logic [31:0] d; logic [3:0] b;
        obs_q.delete(); exp_q.delete();
        rand_wn = 1;
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom; b = 4'($urandom_range(1, 15));
                exp_q.push_back({1'b0, 4'd0, d, b});
                send_cfg(d, b, ok);
            end else begin
                rd_val = $urandom;
                exp_q.push_back({1'b1, 4'd0, rd_val, 4'hF});
                exp_q.push_back({1'b0, 4'd0, rd_val | 32'h2, 4'hF});
                pulse_refresh();
            end
            wait_idle(100, ok);
        end
        rand_wn = 0;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rcfg_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rcfg_xfer%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_rw_exclusive();
        checks++;
        if (rw_clash != 0) begin
            errors++;
            $display("FAIL rw_exclusive: got %0d cycles with read and write expected 0", rw_clash);
        end
    endtask

    // ---- sequence and report ----
    initial begin
        test_reset();
        test_packing();
        test_partial_break();
        test_timeout();
        test_no_timeout();
        test_waitrequest();
        test_refresh();
        test_ordering();
        test_random_pack();
        test_random_cfg_refresh();
        test_rw_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/osd_text_master.md
Name: osd_text_master

Overview:
- Avalon-MM initiator that drives the OSD generator's register slave: config word at address 0, character-pointer words at addresses 1..8 (4 chars per word, char i in byte lane i[1:0]).
- Packs a per-character stream into byte-enabled 32-bit writes and forwards config writes.
- Performs a read-modify-write "status refresh" that sets config bit 1.
- Lets hardware sources (mode detector, status overlay) update OSD text without CPU involvement.

Parameters:
FLUSH_TIMEOUT, 64, idle cycles after the last accepted char before a partial word is flushed; 0 disables timeout flushing
TO_W, 8, width of the timeout counter; FLUSH_TIMEOUT must be < 2^TO_W

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset, asynchronous, active-low
ch_valid  in  1  character request valid
ch_ready  out  1  character accepted when ch_valid && ch_ready
ch_idx  in  5  character position 0..31 (row*16+col)
ch_code  in  8  character ROM code
ch_last  in  1  flush immediately after this char
cfg_valid  in  1  config write request
cfg_ready  out  1  config accepted when cfg_valid && cfg_ready
cfg_data  in  32  config write data
cfg_be  in  4  config byte enables
refresh_req  in  1  single-cycle pulse, request status refresh
busy  out  1  high whenever state != IDLE or accumulator non-empty or refresh pending
avalon_m_address  out  4  word address
avalon_m_writedata  out  32  write data
avalon_m_byteenable  out  4  byte enables
avalon_m_write  out  1  write strobe
avalon_m_read  out  1  read strobe
avalon_m_chipselect  out  1  asserted with write or read
avalon_m_readdata  in  32  read data, valid in the cycle read && waitrequest_n
avalon_m_waitrequest_n  in  1  transfer completes in the cycle this is high

Behaviour:
- Reset (rst_ni low, async): state IDLE; accumulator empty (acc_be=0); refresh pending=0; timeout counter=0; every output 0, including ch_ready, cfg_ready, busy and all avalon_m_*.
- States: IDLE, WR_CHAR, WR_CFG, RD_CFG, WR_REF.
- Accumulator: acc_word[2:0], acc_data[31:0], acc_be[3:0].
- Char accept, IDLE only. ch_ready = !cfg_valid && !pend && (acc_be==0 || (ch_idx[4:2]==acc_word && !acc_be[ch_idx[1:0]])).
  - On accept: write ch_code into lane ch_idx[1:0], set that be bit, load acc_word, clear the timeout counter.
- Flush: IDLE -> WR_CHAR on the next edge when acc_be!=0 and any of the following holds:
  - the char just accepted had ch_last=1;
  - ch_valid is high with a non-mergeable char (different word or lane already set);
  - cfg_valid or pend is high;
  - acc_be==4'hF;
  - FLUSH_TIMEOUT!=0 and the counter reaches FLUSH_TIMEOUT.
  The counter increments each IDLE cycle with acc_be!=0 and no accept.
- WR_CHAR: chipselect=write=1, address=1+acc_word, writedata=acc_data, byteenable=acc_be, all held stable until waitrequest_n=1. On the completion edge: clear acc_be and acc_data, return to IDLE. Min 1 cycle per write.
- Config: cfg_ready = (state==IDLE && acc_be==0 && !pend). On accept, latch data/be, go to WR_CFG: address 0, byteenable=cfg_be, held until waitrequest_n, then IDLE.
- Refresh:
  - refresh_req sets pend in any state, including mid-refresh, which queues exactly one more refresh. Multiple pulses while pend=1 merge.
  - Priority in IDLE with acc empty: cfg_valid first, then pend, then chars.
  - Starting a refresh clears pend and enters RD_CFG: address 0, read=chipselect=1, write=0. On the waitrequest_n=1 edge, capture readdata into rmw.
  - WR_REF writes rmw | 32'h2 with byteenable 4'hF, held until waitrequest_n, then IDLE.
- read and write are never asserted in the same cycle. Outputs are registered and change only on clock edges.
- Ordering: all chars accepted before a cfg/refresh grant reach the bus before that cfg/refresh transfer.
- Reset mid-transfer aborts immediately; no completion is generated.

Test Plan:
- Reset: hold rst_ni=0 with ch_valid=1 -> all outputs 0. Release, then wait 2 cycles -> busy=0, ch_ready=1.
- Packing: chars idx 4..7 codes 0x41..0x44 on consecutive cycles, waitrequest_n=1 -> one write: address 2, data 0x44434241, be 4'hF, started the cycle after the 4th accept.
- Partial and break: idx 0 (0x10), then idx 5 (0x20) -> ch_ready low for idx 5; write address 1, data 0x00000010, be 4'b0001. idx 5 is then accepted and later written to address 2, be 4'b0010.
- Timeout: single char idx 31 code 0x7F, no further input -> write address 8, data 0x7F000000, be 4'b1000, starting FLUSH_TIMEOUT cycles after accept (±1). With FLUSH_TIMEOUT=0 -> no write until ch_last.
- Waitrequest: cfg_valid data 0x00006005 be 4'h3, waitrequest_n low for 3 cycles -> address/data/be/write stable for 4 cycles, exactly one completion, cfg_ready low throughout.
- Refresh RMW: readdata returns 0x00006005, plus a second refresh_req during RD_CFG -> write 0x00006007 be 4'hF, followed by a second read/write pair, then busy=0.
